child_fsm: RTL and testbench

Counterpart FSM to the parent sequencer: the child sleeps for a fixed interval, raises `wakeup`, consumes the `food` and `book` events the parent produces, and returns to sleep. It sits beside the parent at the same hierarchy level on the same clock: its `wakeup` output drives the parent's `wakeup` input, and the parent's `food`/`book` outputs drive its inputs. Timeouts and a meal counter give the verification bench observable progress and error status.

---
 rtl/child_fsm_pkg.sv | 28 ++
 rtl/child_fsm_rise_detect.sv | 18 +
 rtl/child_fsm.sv | 123 ++++++++++++
 tb/tb_child_fsm.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/child_fsm_pkg.sv
// Shared definitions for the child FSM: state encodings, default timing
// parameters and a small sizing helper.
package child_fsm_pkg;

  // Prefixed names keep clear of the parent sequencer's P0..P2 states.
  typedef enum logic [2:0] {
    ST_SLEEP     = 3'd0,
    ST_WAKE      = 3'd1,
    ST_EAT       = 3'd2,
    ST_WAIT_BOOK = 3'd3,
    ST_READ      = 3'd4
  } child_state_e;

  localparam int DEF_SLEEP_CYC = 8;
  localparam int DEF_EAT_CYC   = 3;
  localparam int DEF_READ_CYC  = 4;
  localparam int DEF_TIMEOUT   = 16;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/child_fsm_rise_detect.sv
// Single-flop rising-edge detector; the history flop resets low.
module rise_detect (
  input  logic clk,
  input  logic resetb,
  input  logic x,
  output logic rise
);

  logic x_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) x_q <= 1'b0;
    else         x_q <= x;
  end

  assign rise = x & ~x_q;

endmodule

// File: rtl/child_fsm.sv
// Child side of the parent/child handshake: sleep, wake, eat on food, read on
// book, with per-wait timeouts, a sticky error flag and a saturating meal count.
module child_fsm
  import child_fsm_pkg::*;
#(
  parameter int SLEEP_CYC = DEF_SLEEP_CYC,
  parameter int EAT_CYC   = DEF_EAT_CYC,
  parameter int READ_CYC  = DEF_READ_CYC,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       food,
  input  logic       book,
  output logic       wakeup,
  output logic       eating,
  output logic       reading,
  output logic       timeout_err,
  output logic [7:0] meal_cnt
);

  localparam int MAX_P = max_of4(SLEEP_CYC, EAT_CYC, READ_CYC, TIMEOUT);
  localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  child_state_e     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             book_pend;
  logic             food_rise, book_rise;
  logic             set_err, inc_meal, set_pend, clr_pend;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic at_last(input logic [CNT_W-1:0] c, input int limit);
    return int'(c) == (limit - 1);
  endfunction

  rise_detect u_food_rise (
    .clk    (clk),
    .resetb (resetb),
    .x      (food),
    .rise   (food_rise)
  );

  rise_detect u_book_rise (
    .clk    (clk),
    .resetb (resetb),
    .x      (book),
    .rise   (book_rise)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_SLEEP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    inc_meal  = 1'b0;
    set_pend  = 1'b0;
    clr_pend  = 1'b0;
    case (state)
      ST_SLEEP: begin
        if (at_last(cnt, SLEEP_CYC)) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (food_rise) begin
          state_nxt = ST_EAT;
          inc_meal  = 1'b1;
          set_pend  = book_rise;
        end else if (at_last(cnt, TIMEOUT)) begin
          state_nxt = ST_SLEEP;
          set_err   = 1'b1;
        end
      end
      ST_EAT: begin
        set_pend = book_rise;
        // A book arriving on the final EAT cycle still counts as pending.
        if (at_last(cnt, EAT_CYC)) begin
          clr_pend  = 1'b1;
          state_nxt = (book_pend | book_rise) ? ST_READ : ST_WAIT_BOOK;
        end
      end
      ST_WAIT_BOOK: begin
        if (book_rise) begin
          state_nxt = ST_READ;
        end else if (at_last(cnt, TIMEOUT)) begin
          state_nxt = ST_SLEEP;
          set_err   = 1'b1;
        end
      end
      ST_READ: begin
        if (at_last(cnt, READ_CYC)) state_nxt = ST_SLEEP;
      end
      default: state_nxt = ST_SLEEP;
    endcase
    if (state_nxt == ST_SLEEP && state != ST_SLEEP) clr_pend = 1'b1;
  end

  // Dwell counter restarts on every state change.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt         <= '0;
      book_pend   <= 1'b0;
      timeout_err <= 1'b0;
      meal_cnt    <= 8'd0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      if (clr_pend)      book_pend <= 1'b0;
      else if (set_pend) book_pend <= 1'b1;
      if (set_err)  timeout_err <= 1'b1;
      if (inc_meal) meal_cnt    <= sat_inc8(meal_cnt);
    end
  end

  assign wakeup  = (state == ST_WAKE);
  assign eating  = (state == ST_EAT);
  assign reading = (state == ST_READ);

endmodule

// File: tb/tb_child_fsm.sv
// Bench for child_fsm: directed vector table, multi-cycle corner sequences and
// random stimulus compared every cycle against a phase/duration model.
module tb_child_fsm;

  localparam int SLEEP_CYC = 8;
  localparam int EAT_CYC   = 3;
  localparam int READ_CYC  = 4;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       food = 1'b0;
  logic       book = 1'b0;
  logic       wakeup, eating, reading, timeout_err;
  logic [7:0] meal_cnt;

  int checks = 0;
  int failures = 0;

  child_fsm #(
    .SLEEP_CYC (SLEEP_CYC),
    .EAT_CYC   (EAT_CYC),
    .READ_CYC  (READ_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .food        (food),
    .book        (book),
    .wakeup      (wakeup),
    .eating      (eating),
    .reading     (reading),
    .timeout_err (timeout_err),
    .meal_cnt    (meal_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which activity the child is in and how long it has been there.
  typedef enum int {PH_SLEEP, PH_WAKE, PH_EAT, PH_WAIT, PH_READ} phase_e;
  phase_e m_phase;
  int     m_spent;
  bit     m_pend, m_err, m_fq, m_bq;
  int     m_meals;

  task automatic m_reset();
    m_phase = PH_SLEEP; m_spent = 0; m_pend = 0; m_err = 0;
    m_meals = 0; m_fq = 0; m_bq = 0;
  endtask

  task automatic m_goto(input phase_e p);
    m_phase = p;
    m_spent = 0;
    if (p == PH_SLEEP) m_pend = 0;
  endtask

  task automatic m_step(input bit f, input bit b);
    bit fr, br;
    fr = f && !m_fq;
    br = b && !m_bq;
    m_fq = f;
    m_bq = b;
    m_spent++;
    case (m_phase)
      PH_SLEEP: if (m_spent == SLEEP_CYC) m_goto(PH_WAKE);
      PH_WAKE: begin
        if (fr) begin
          m_meals = (m_meals < 255) ? m_meals + 1 : 255;
          m_goto(PH_EAT);
          m_pend = br;
        end else if (m_spent == TIMEOUT) begin
          m_err = 1;
          m_goto(PH_SLEEP);
        end
      end
      PH_EAT: begin
        if (br) m_pend = 1;
        if (m_spent == EAT_CYC) begin
          if (m_pend) m_goto(PH_READ);
          else        m_goto(PH_WAIT);
          m_pend = 0;
        end
      end
      PH_WAIT: begin
        if (br) m_goto(PH_READ);
        else if (m_spent == TIMEOUT) begin
          m_err = 1;
          m_goto(PH_SLEEP);
        end
      end
      PH_READ: if (m_spent == READ_CYC) m_goto(PH_SLEEP);
      default: m_goto(PH_SLEEP);
    endcase
  endtask

  function automatic logic [15:0] m_out();
    logic [7:0] mc;
    mc = 8'(m_meals);
    return {4'd0, m_phase == PH_WAKE, m_phase == PH_EAT, m_phase == PH_READ, m_err, mc};
  endfunction

  function automatic logic [15:0] dut_out();
    return {4'd0, wakeup, eating, reading, timeout_err, meal_cnt};
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic step(input logic f, input logic b);
    food = f;
    book = b;
    @(posedge clk);
    if (!resetb) m_reset();
    else         m_step(f, b);
    #1;
    check("model", dut_out(), m_out());
  endtask

  task automatic wait_wakeup();
    int n;
    n = 0;
    while (!wakeup && n < 40) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("wake_reached", {15'd0, wakeup}, 16'd1);
  endtask

  task automatic run_loop();
    int n;
    wait_wakeup();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n = 0;
    while ((eating || reading) && n < 20) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("loop_sleep", {14'd0, eating, reading}, 16'd0);
  endtask

  typedef struct {
    logic       f, b;
    logic       w, e, r, err;
    logic [7:0] meal;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input logic f, input logic b, input logic w,
                     input logic e, input logic r, input logic [7:0] meal);
    vec_t v;
    v.f = f; v.b = b; v.w = w; v.e = e; v.r = r; v.err = 1'b0; v.meal = meal;
    repeat (n) tbl.push_back(v);
  endtask

  initial begin
    int n;
    // Reset idle with both levels high, then a nominal loop and a
    // simultaneous food/book loop with an ignored food pulse during READ.
    add(7, 1, 1, 0, 0, 0, 8'd0);
    add(1, 1, 1, 1, 0, 0, 8'd0);
    add(1, 0, 0, 1, 0, 0, 8'd0);
    add(1, 1, 0, 0, 1, 0, 8'd1);
    add(2, 1, 1, 0, 1, 0, 8'd1);
    add(1, 1, 1, 0, 0, 1, 8'd1);
    add(3, 0, 0, 0, 0, 1, 8'd1);
    add(8, 0, 0, 0, 0, 0, 8'd1);
    add(1, 0, 0, 1, 0, 0, 8'd1);
    add(3, 1, 1, 0, 1, 0, 8'd2);
    add(1, 0, 0, 0, 0, 1, 8'd2);
    add(1, 1, 0, 0, 0, 1, 8'd2);
    add(2, 0, 0, 0, 0, 1, 8'd2);
    add(1, 0, 0, 0, 0, 0, 8'd2);

    resetb = 1'b0;
    m_reset();
    repeat (3) step(1'b1, 1'b1);
    check("reset_outputs", dut_out(), 16'd0);
    resetb = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].b);
      check($sformatf("vec%0d", i + 1), dut_out(),
            {4'd0, tbl[i].w, tbl[i].e, tbl[i].r, tbl[i].err, tbl[i].meal});
    end

    // Late book: five WAIT_BOOK cycles, then four READ cycles, no error.
    wait_wakeup();
    step(1'b1, 1'b0);
    check("late_eat", {15'd0, eating}, 16'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("late_wait0", {13'd0, wakeup, eating, reading}, 16'd0);
    repeat (4) step(1'b0, 1'b0);
    check("late_wait4", {13'd0, wakeup, eating, reading}, 16'd0);
    step(1'b0, 1'b1);
    check("late_read", {15'd0, reading}, 16'd1);
    repeat (3) step(1'b0, 1'b1);
    check("late_read4", {15'd0, reading}, 16'd1);
    step(1'b0, 1'b0);
    check("late_read_end", {15'd0, reading}, 16'd0);
    check("late_no_err", {15'd0, timeout_err}, 16'd0);

    // Food timeout: wakeup for TIMEOUT cycles, sticky error, next loop works.
    wait_wakeup();
    n = 1;
    while (wakeup && n < 40) begin
      step(1'b0, 1'b0);
      if (wakeup) n++;
    end
    check("food_to_len", 16'(n), 16'd16);
    check("food_to_err", {15'd0, timeout_err}, 16'd1);
    run_loop();
    check("err_sticky", {15'd0, timeout_err}, 16'd1);
    check("meals_after_to", {8'd0, meal_cnt}, 16'd4);

    // Reset mid-EAT: outputs drop before the next clock edge.
    wait_wakeup();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_reset_eat", {15'd0, eating}, 16'd1);
    resetb = 1'b0;
    #1;
    check("async_reset", dut_out(), 16'd0);
    m_reset();
    step(1'b1, 1'b1);
    resetb = 1'b1;
    n = 0;
    while (!wakeup && n < 40) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("restart_sleep", 16'(n), 16'd8);

    // Saturation of the meal counter.
    repeat (260) run_loop();
    check("meal_sat", {8'd0, meal_cnt}, 16'd255);
    check("sat_no_err", {15'd0, timeout_err}, 16'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
